// File: rtl/mrsw_ram_sync_pkg.sv
// Shared definitions for the multi-read single-write RAM: collision modes and FSM state encoding.
package mrsw_ram_sync_pkg;

   localparam int RD_MODE_READ_FIRST  = 0;
   localparam int RD_MODE_WRITE_FIRST = 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/mrsw_ram_bank.sv
// One 1W1R bank: unreset storage array, registered read with optional write-first bypass.
module mrsw_ram_bank
   import mrsw_ram_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 2 ** ADDR_WIDTH,
   parameter int WRITE_FIRST = RD_MODE_READ_FIRST
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  rd_zero,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam bit BYPASS = (WRITE_FIRST == RD_MODE_WRITE_FIRST);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // rd_zero covers out-of-range addresses, so mem_q is never indexed past its end
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (rd_zero) begin
            rd_data_d = '0;
         end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_addr];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mrsw_ram_sync.sv
// Multi-read single-write RAM: NUM_RD replicated banks sharing one write, with zero-fill after reset.
module mrsw_ram_sync
   import mrsw_ram_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 2 ** ADDR_WIDTH,
   parameter int NUM_RD      = 2,
   parameter int WRITE_FIRST = RD_MODE_READ_FIRST
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         wr_ready,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_valid,
   output logic                         init_busy
);

   localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic                    init_busy_q, init_busy_d;
   logic                    wr_ready_q, wr_ready_d;
   logic [NUM_RD-1:0]       rd_valid_q, rd_valid_d;

   logic                    bank_we;
   logic [ADDR_WIDTH-1:0]   bank_waddr;
   logic [DATA_WIDTH-1:0]   bank_wdata;
   logic [NUM_RD-1:0]       rd_fire;
   logic [NUM_RD-1:0]       rd_oor;

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_busy_d = init_busy_q;
      wr_ready_d  = wr_ready_q;
      bank_we     = 1'b0;
      bank_waddr  = wr_addr;
      bank_wdata  = wr_data;
      rd_fire     = '0;
      rd_oor      = '0;

      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_oor[p] = ({1'b0, rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} >= DEPTH);
      end

      case (state_q)
         ST_INIT: begin
            bank_we    = 1'b1;
            bank_waddr = init_cnt_q;
            bank_wdata = '0;
            // busy/ready flip at the same edge as the last fill write
            if (init_cnt_q == LAST_ADDR) begin
               state_d     = ST_RUN;
               init_cnt_d  = '0;
               init_busy_d = 1'b0;
               wr_ready_d  = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            end
         end
         ST_RUN: begin
            bank_we = wr_en && wr_ready_q && ({1'b0, wr_addr} < DEPTH);
            rd_fire = rd_en;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      rd_valid_d = rd_fire;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         init_busy_q <= 1'b1;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_busy_q <= init_busy_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_bank
      mrsw_ram_bank #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .DATA_WIDTH  (DATA_WIDTH),
         .MEM_DEPTH   (MEM_DEPTH),
         .WRITE_FIRST (WRITE_FIRST)
      ) u_bank (
         .clock   (clock),
         .reset_n (reset_n),
         .wr_en   (bank_we),
         .wr_addr (bank_waddr),
         .wr_data (bank_wdata),
         .rd_en   (rd_fire[g]),
         .rd_zero (rd_oor[g]),
         .rd_addr (rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .rd_data (rd_data[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign wr_ready  = wr_ready_q;
   assign rd_valid  = rd_valid_q;
   assign init_busy = init_busy_q;

endmodule

// File: tb/tb_mrsw_ram_sync.sv
// Directed bench for mrsw_ram_sync: read-first, write-first and short-depth instances on shared stimulus.
module tb_mrsw_ram_sync;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [1:0]  rd_en = '0;
   logic [15:0] rd_addr = '0;

   logic [15:0] rd_data_m, rd_data_w, rd_data_s;
   logic [1:0]  rd_valid_m, rd_valid_w, rd_valid_s;
   logic        busy_m, busy_w, busy_s;
   logic        ready_m, ready_w, ready_s;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   mrsw_ram_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .NUM_RD(2), .WRITE_FIRST(0)) dut_m (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(ready_m), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_m),
      .rd_valid(rd_valid_m), .init_busy(busy_m));

   mrsw_ram_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .NUM_RD(2), .WRITE_FIRST(1)) dut_w (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(ready_w), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w),
      .rd_valid(rd_valid_w), .init_busy(busy_w));

   mrsw_ram_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .NUM_RD(2), .WRITE_FIRST(0)) dut_s (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(ready_s), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
      .rd_valid(rd_valid_s), .init_busy(busy_s));

   typedef struct {
      logic       we;
      logic [7:0] wa;
      logic [7:0] wd;
      logic [1:0] re;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [1:0] ev;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic [1:0] re, input logic [7:0] a0, input logic [7:0] a1);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_en   = re;
      rd_addr = {a1, a0};
   endtask

   // Counts edges after reset release until init_busy drops on each depth variant.
   task automatic run_init(input string tag);
      int c_m = 0;
      int c_s = 0;
      int vbad = 0;
      for (int c = 1; c <= 400; c++) begin
         tick();
         if (c_m == 0 && busy_m) begin
            if (rd_valid_m != 2'b00 || ready_m) vbad++;
         end
         if (c_m == 0 && !busy_m) c_m = c;
         if (c_s == 0 && !busy_s) c_s = c;
         if (c_m != 0 && c_s != 0) break;
      end
      chk({tag, "_len256"}, c_m, 256);
      chk({tag, "_len200"}, c_s, 200);
      chk({tag, "_quiet_during_init"}, vbad, 0);
      chk({tag, "_ready"}, {ready_m, ready_w, ready_s}, 3'b111);
   endtask

   initial begin
      tv[0]  = '{1'b1, 8'd3,  8'h5A, 2'b00, 8'd0,   8'd0,  8'h00, 8'h00, 2'b00};
      tv[1]  = '{1'b1, 8'd7,  8'hC3, 2'b00, 8'd0,   8'd0,  8'h00, 8'h00, 2'b00};
      tv[2]  = '{1'b0, 8'd0,  8'h00, 2'b11, 8'd3,   8'd7,  8'h5A, 8'hC3, 2'b11};
      tv[3]  = '{1'b0, 8'd0,  8'h00, 2'b11, 8'd7,   8'd3,  8'hC3, 8'h5A, 2'b11};
      tv[4]  = '{1'b1, 8'd3,  8'h77, 2'b01, 8'd3,   8'd0,  8'h5A, 8'h5A, 2'b01};
      tv[5]  = '{1'b0, 8'd0,  8'h00, 2'b10, 8'd0,   8'd3,  8'h5A, 8'h77, 2'b10};
      tv[6]  = '{1'b0, 8'd0,  8'h00, 2'b11, 8'd255, 8'd0,  8'h00, 8'h00, 2'b11};
      tv[7]  = '{1'b1, 8'd20, 8'hA5, 2'b00, 8'd0,   8'd0,  8'h00, 8'h00, 2'b00};
      tv[8]  = '{1'b0, 8'd0,  8'h00, 2'b10, 8'd0,   8'd20, 8'h00, 8'hA5, 2'b10};
      tv[9]  = '{1'b0, 8'd0,  8'h00, 2'b00, 8'd0,   8'd3,  8'h00, 8'hA5, 2'b00};
      tv[10] = '{1'b0, 8'd0,  8'h00, 2'b10, 8'd0,   8'd3,  8'h00, 8'h77, 2'b10};

      // reset state
      #23;
      chk("reset_outputs", {busy_m, ready_m, rd_valid_m, rd_data_m}, {1'b1, 1'b0, 2'b00, 16'h0000});
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b0, 8'd0, 8'h00, 2'b11, 8'd0, 8'd0);
      run_init("init1");
      drive(1'b0, 8'd0, 8'h00, 2'b00, 8'd0, 8'd0);

      // every address reads back zero after the fill
      for (int a = 0; a < 256; a++) begin
         drive(1'b0, 8'd0, 8'h00, 2'b11, 8'(a), 8'(255 - a));
         tick();
         chk("zero_fill", {rd_valid_m, rd_data_m}, {2'b11, 16'h0000});
      end

      // table: write/read, read-first collision, per-port enable gating and hold
      for (int i = 0; i < 11; i++) begin
         drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].a0, tv[i].a1);
         tick();
         chk($sformatf("vec%0d_d0", i), rd_data_m[7:0], tv[i].e0);
         chk($sformatf("vec%0d_d1", i), rd_data_m[15:8], tv[i].e1);
         chk($sformatf("vec%0d_valid", i), rd_valid_m, tv[i].ev);
      end

      // collision at address 9 on both modes
      drive(1'b1, 8'd9, 8'h11, 2'b00, 8'd0, 8'd0);
      tick();
      drive(1'b1, 8'd9, 8'h22, 2'b01, 8'd9, 8'd0);
      tick();
      chk("coll_read_first", rd_data_m[7:0], 8'h11);
      chk("coll_write_first", rd_data_w[7:0], 8'h22);
      chk("coll_depth200", rd_data_s[7:0], 8'h11);
      chk("coll_valid", {rd_valid_m, rd_valid_w}, 4'b0101);
      drive(1'b0, 8'd0, 8'h00, 2'b01, 8'd9, 8'd0);
      tick();
      chk("coll_after_rf", rd_data_m[7:0], 8'h22);
      chk("coll_after_wf", rd_data_w[7:0], 8'h22);

      // out-of-range on the 200-deep instance
      drive(1'b1, 8'd210, 8'hFF, 2'b00, 8'd0, 8'd0);
      tick();
      drive(1'b1, 8'd199, 8'h42, 2'b00, 8'd0, 8'd0);
      tick();
      drive(1'b0, 8'd0, 8'h00, 2'b11, 8'd210, 8'd199);
      tick();
      chk("oor_read_zero", rd_data_s[7:0], 8'h00);
      chk("oor_valid", rd_valid_s, 2'b11);
      chk("last_addr_200", rd_data_s[15:8], 8'h42);
      chk("addr210_full_depth", rd_data_m[7:0], 8'hFF);
      drive(1'b0, 8'd0, 8'h00, 2'b00, 8'd0, 8'd0);

      // asynchronous reset from RUN clears outputs immediately
      tick();
      reset_n = 1'b0;
      #2;
      chk("async_reset", {busy_m, ready_m, rd_valid_m, rd_data_m}, {1'b1, 1'b0, 2'b00, 16'h0000});
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 8'd3, 8'hEE, 2'b11, 8'd3, 8'd20);
      for (int c = 0; c < 100; c++) tick();
      chk("mid_init_busy", {busy_m, ready_m}, 2'b10);

      // reset again at init_cnt=100: fill restarts and runs full length
      reset_n = 1'b0;
      #2;
      @(negedge clock);
      reset_n = 1'b1;
      run_init("init2");
      drive(1'b0, 8'd0, 8'h00, 2'b11, 8'd3, 8'd20);
      tick();
      chk("init_wr_ignored", {rd_valid_m, rd_data_m}, {2'b11, 16'h0000});
      drive(1'b0, 8'd0, 8'h00, 2'b00, 8'd0, 8'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
